// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared constants and FSM encoding for the sequential divider
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_trial_sub.sv
// rtl/seq_divider_trial_sub.sv - ripple subtractor of 1-bit full-subtractor cells
module trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] difference,
    output logic         borrow_out
);

    logic [W:0] w_borrow;

    assign w_borrow[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign difference[i]  = minuend[i] ^ subtrahend[i] ^ w_borrow[i];
        assign w_borrow[i+1]  = (~minuend[i] & subtrahend[i])
                              | (~(minuend[i] ^ subtrahend[i]) & w_borrow[i]);
    end

    assign borrow_out = w_borrow[W];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring radix-2 divider, one quotient bit per clock
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dq;          // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_keep;
    logic [WIDTH:0]   w_next_rem;
    logic [WIDTH-1:0] w_next_dq;
    logic             w_last;
    logic             w_zero;

    assign w_shift = {r_rem[WIDTH-1:0], r_dq[WIDTH-1]};

    trial_sub #(.W(WIDTH + 1)) u_trial_sub (
        .minuend    (w_shift),
        .subtrahend ({1'b0, r_divisor}),
        .difference (w_diff),
        .borrow_out (w_borrow)
    );

    // A set remainder MSB would be shifted out above the divisor's range, so it always fits.
    assign w_keep     = ~w_borrow | r_rem[WIDTH];
    assign w_next_rem = w_keep ? w_diff : w_shift;
    assign w_next_dq  = {r_dq[WIDTH-2:0], w_keep};
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_zero     = (r_divisor == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_divisor   <= '0;
            r_dq        <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_divisor <= divisor;
                        r_dq      <= dividend;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_ready   <= 1'b0;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (w_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dq;
                        r_dbz       <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_rem <= w_next_rem;
                        r_dq  <= w_next_dq;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quotient  <= w_next_dq;
                            r_remainder <= w_next_rem[WIDTH-1:0];
                            r_dbz       <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
